// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared state encoding, register offsets and wait-counter width for the APB register slave.
package apb_slave_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
    localparam logic [5:0] REG_WAIT_CFG = 6'h10;
    localparam logic [5:0] REG_XFER_CNT = 6'h11;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/apb_slave_wait_ctr.sv
// apb_slave_wait_ctr: loadable down-counter that saturates at zero and flags when the wait budget is spent.
module apb_slave_wait_ctr
    import apb_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);
    logic [WAIT_W-1:0] cnt;

    assign zero = cnt == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB slave with a bank of RW registers, a runtime wait-state register
// and a read-only count of completed transfers.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int WAIT_DEFAULT = 0,
    parameter int DATA_W       = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [31:0]       PADDR,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY
);
    state_e            state, phase;
    logic [5:0]        addr;
    logic              wr;
    logic [DATA_W-1:0] wdata, xfer_cnt, rd_val;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [WAIT_W-1:0] wait_cfg;
    logic              capture, access, ready, zero, unused;

    // Any select outside ACCESS is a setup phase, which also absorbs PSEL&PENABLE seen in IDLE
    // and the back-to-back setup following a completed transfer.
    assign phase   = (state == ACCESS) ? ACCESS : (PSEL ? SETUP : IDLE);
    assign capture = phase == SETUP;
    assign access  = state == ACCESS && PSEL && PENABLE;
    assign ready   = access && zero;
    assign PREADY  = ready;
    assign PRDATA  = (ready && !wr) ? rd_val : '0;
    assign unused  = ^{PADDR[31:8], PADDR[1:0]};

    apb_slave_wait_ctr u_wait (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .load    (capture),
        .load_val(wait_cfg),
        .dec     (access),
        .zero    (zero)
    );

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr == 6'(i)) rd_val = regs[i];
        if (addr == REG_WAIT_CFG) rd_val = {{(DATA_W-WAIT_W){1'b0}}, wait_cfg};
        if (addr == REG_XFER_CNT) rd_val = xfer_cnt;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            addr     <= '0;
            wr       <= 1'b0;
            wdata    <= '0;
            wait_cfg <= WAIT_W'(WAIT_DEFAULT);
            xfer_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (capture) begin
                state <= ACCESS;
                addr  <= PADDR[7:2];
                wr    <= PWRITE;
                wdata <= PWDATA;
            end else if (state == ACCESS && (!PSEL || ready)) begin
                state <= IDLE;
            end
            if (ready) begin
                xfer_cnt <= xfer_cnt + 1'b1;
                if (wr && addr == REG_WAIT_CFG) wait_cfg <= wdata[WAIT_W-1:0];
                for (int i = 0; i < NUM_REGS; i++)
                    if (wr && addr == 6'(i)) regs[i] <= wdata;
            end
        end
    end
endmodule
